// File: rtl/gpio_bank_pkg.sv
// -----------------------------------------------------------------------------
// gpio_bank_pkg
// Shared definitions for the GPIO bank on the FemtoRV32 IO page: register
// word indices, register-bus widths and the maximum supported pin count.
// No ports (package).
// -----------------------------------------------------------------------------
package gpio_bank_pkg;

   localparam int REG_ADDR_W = 4;
   localparam int REG_DATA_W = 32;
   localparam int MAX_WIDTH  = 32;

   // Word register indices (SoC byte address bits [5:2])
   localparam logic [REG_ADDR_W-1:0] GPIO_IN      = 4'd0;
   localparam logic [REG_ADDR_W-1:0] GPIO_OUT     = 4'd1;
   localparam logic [REG_ADDR_W-1:0] GPIO_OUT_SET = 4'd2;
   localparam logic [REG_ADDR_W-1:0] GPIO_OUT_CLR = 4'd3;
   localparam logic [REG_ADDR_W-1:0] GPIO_OUT_TGL = 4'd4;
   localparam logic [REG_ADDR_W-1:0] GPIO_DIR     = 4'd5;
   localparam logic [REG_ADDR_W-1:0] GPIO_RISE_EN = 4'd6;
   localparam logic [REG_ADDR_W-1:0] GPIO_FALL_EN = 4'd7;
   localparam logic [REG_ADDR_W-1:0] GPIO_EVENT   = 4'd8;
   localparam logic [REG_ADDR_W-1:0] GPIO_IRQ_EN  = 4'd9;

endpackage

// File: rtl/gpio_bank_if.sv
// -----------------------------------------------------------------------------
// gpio_bank_if
// Processor-side register bus of the GPIO bank.
//   reg_addr  : word register index
//   reg_wstrb : one-cycle write strobe
//   reg_rstrb : one-cycle read strobe
//   reg_wdata : write data
//   reg_rdata : registered read data (valid the cycle after reg_rstrb)
// master = processor side, slave = GPIO bank side.
// -----------------------------------------------------------------------------
interface gpio_bank_if;
   import gpio_bank_pkg::*;

   logic [REG_ADDR_W-1:0] reg_addr;
   logic                  reg_wstrb;
   logic                  reg_rstrb;
   logic [REG_DATA_W-1:0] reg_wdata;
   logic [REG_DATA_W-1:0] reg_rdata;

   modport master (
      output reg_addr, reg_wstrb, reg_rstrb, reg_wdata,
      input  reg_rdata
   );

   modport slave (
      input  reg_addr, reg_wstrb, reg_rstrb, reg_wdata,
      output reg_rdata
   );

endinterface

// File: rtl/gpio_sync.sv
// -----------------------------------------------------------------------------
// gpio_sync
// Synchronises asynchronous pad inputs into the clk domain and produces the
// unmasked per-bit edge terms.
//   clk, reset : system clock, synchronous active-high reset
//   d          : raw pad inputs (asynchronous)
//   q          : synchronised inputs (last stage of the chain)
//   rise_raw   : q high now, low one cycle earlier
//   fall_raw   : q low now, high one cycle earlier
// -----------------------------------------------------------------------------
module gpio_sync #(
   parameter int WIDTH       = 24,
   parameter int SYNC_STAGES = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q,
   output logic [WIDTH-1:0] rise_raw,
   output logic [WIDTH-1:0] fall_raw
);

   // Element 0 samples the pad; element SYNC_STAGES-1 is the synchronised value.
   logic [SYNC_STAGES-1:0][WIDTH-1:0] chain_q;
   logic [WIDTH-1:0]                  prev_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         chain_q <= '0;
         prev_q  <= '0;
      end else begin
         chain_q <= {chain_q[SYNC_STAGES-2:0], d};
         prev_q  <= chain_q[SYNC_STAGES-1];
      end
   end

   assign q        = chain_q[SYNC_STAGES-1];
   assign rise_raw =  q & ~prev_q;
   assign fall_raw = ~q &  prev_q;

endmodule

// File: rtl/gpio_bank.sv
// -----------------------------------------------------------------------------
// gpio_bank
// Parametrised memory-mapped GPIO bank: synchronised inputs, atomic
// set/clear/toggle of outputs, per-pin rising/falling edge capture into
// write-1-to-clear event flags, and a maskable level interrupt.
//   clk, reset : system clock, synchronous active-high reset
//   bus        : register bus (gpio_bank_if.slave)
//   port_in    : raw pad inputs (asynchronous)
//   port_out   : pad output values (SB_IO D_OUT)
//   port_dir   : pad output enables, 1 = output (SB_IO OUTPUT_ENABLE)
//   irq        : |(EVENT & IRQ_EN)
// -----------------------------------------------------------------------------
module gpio_bank
   import gpio_bank_pkg::*;
#(
   parameter int               WIDTH       = 24,
   parameter int               SYNC_STAGES = 2,
   parameter logic [WIDTH-1:0] RESET_OUT   = '0,
   parameter logic [WIDTH-1:0] RESET_DIR   = '0
) (
   input  logic             clk,
   input  logic             reset,
   gpio_bank_if.slave       bus,
   input  logic [WIDTH-1:0] port_in,
   output logic [WIDTH-1:0] port_out,
   output logic [WIDTH-1:0] port_dir,
   output logic             irq
);

   logic [WIDTH-1:0]      sync_q;
   logic [WIDTH-1:0]      rise_raw;
   logic [WIDTH-1:0]      fall_raw;
   logic [WIDTH-1:0]      rise_en_q;
   logic [WIDTH-1:0]      fall_en_q;
   logic [WIDTH-1:0]      event_q;
   logic [WIDTH-1:0]      irq_en_q;
   logic [REG_DATA_W-1:0] rdata_q;
   logic [REG_DATA_W-1:0] rd_mux;
   logic [WIDTH-1:0]      wdata_w;
   logic [WIDTH-1:0]      w1c_mask;
   logic                  unused_wdata;

   gpio_sync #(
      .WIDTH       (WIDTH),
      .SYNC_STAGES (SYNC_STAGES)
   ) u_sync (
      .clk      (clk),
      .reset    (reset),
      .d        (port_in),
      .q        (sync_q),
      .rise_raw (rise_raw),
      .fall_raw (fall_raw)
   );

   // Write bits above WIDTH are dropped; the reduction only keeps them referenced.
   assign wdata_w      = bus.reg_wdata[WIDTH-1:0];
   assign unused_wdata = ^bus.reg_wdata;

   assign w1c_mask = (bus.reg_wstrb && bus.reg_addr == GPIO_EVENT) ? wdata_w : '0;

   // Read mux; write-only and unmapped indices read 0, upper bits read 0.
   always_comb begin
      rd_mux = '0;
      case (bus.reg_addr)
         GPIO_IN:      rd_mux[WIDTH-1:0] = sync_q;
         GPIO_OUT:     rd_mux[WIDTH-1:0] = port_out;
         GPIO_DIR:     rd_mux[WIDTH-1:0] = port_dir;
         GPIO_RISE_EN: rd_mux[WIDTH-1:0] = rise_en_q;
         GPIO_FALL_EN: rd_mux[WIDTH-1:0] = fall_en_q;
         GPIO_EVENT:   rd_mux[WIDTH-1:0] = event_q;
         GPIO_IRQ_EN:  rd_mux[WIDTH-1:0] = irq_en_q;
         default:      rd_mux = '0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         port_out  <= RESET_OUT;
         port_dir  <= RESET_DIR;
         rise_en_q <= '0;
         fall_en_q <= '0;
         event_q   <= '0;
         irq_en_q  <= '0;
         rdata_q   <= '0;
      end else begin
         // Read captures the pre-write view when both strobes coincide.
         if (bus.reg_rstrb)
            rdata_q <= rd_mux;

         // Edges are OR-ed in after the clear, so a fresh edge wins over W1C.
         event_q <= (event_q & ~w1c_mask)
                  | (rise_raw & rise_en_q)
                  | (fall_raw & fall_en_q);

         if (bus.reg_wstrb) begin
            case (bus.reg_addr)
               GPIO_OUT:     port_out  <= wdata_w;
               GPIO_OUT_SET: port_out  <= port_out | wdata_w;
               GPIO_OUT_CLR: port_out  <= port_out & ~wdata_w;
               GPIO_OUT_TGL: port_out  <= port_out ^ wdata_w;
               GPIO_DIR:     port_dir  <= wdata_w;
               GPIO_RISE_EN: rise_en_q <= wdata_w;
               GPIO_FALL_EN: fall_en_q <= wdata_w;
               GPIO_IRQ_EN:  irq_en_q  <= wdata_w;
               default:      ;
            endcase
         end
      end
   end

   assign bus.reg_rdata = rdata_q;
   assign irq           = |(event_q & irq_en_q);

endmodule
